node_irq_scheduler: RTL and testbench

- Round-robin scheduler for the 32 per-bus IRQ/success request lines after they are registered into a 32-bit vector.
- Latches each request as sticky pending and grants one bus at a time to the shared downstream CAN message handler.
- Sequences each grant through an accept/done handshake with timeout recovery.
- Sits between the request decoder/register stage and the shared transaction engine.

---
 rtl/node_irq_scheduler.sv | 150 +++++++++++++++
 tb/tb_node_irq_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/node_irq_scheduler.sv
// Round-robin IRQ scheduler: latches rising edges of per-bus request lines as
// sticky pending bits and hands them one at a time to a shared downstream
// handler through a grant/ack/done handshake, with timeout recovery.
module node_irq_scheduler #(
  parameter int N_BUS       = 32,
  parameter int ID_W        = 5,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BUS-1:0] req_in,
  input  logic             en,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id,
  output logic [N_BUS-1:0] grant_onehot,
  input  logic             grant_ack,
  input  logic             done,
  output logic             timeout_err,
  output logic [N_BUS-1:0] pending_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    GRANT  = 2'd2,
    WAIT   = 2'd3
  } state_t;

  state_t           state_q;
  logic [N_BUS-1:0] req_q;
  logic [N_BUS-1:0] pending_q;
  logic [N_BUS-1:0] pending_d;
  logic [N_BUS-1:0] rise;
  logic [N_BUS-1:0] clr_mask;
  logic [N_BUS-1:0] grant_onehot_q;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  grant_id_q;
  logic [ID_W-1:0]  sel_id;
  logic             sel_found;
  logic [CNT_W-1:0] cnt_q;
  logic             grant_valid_q;
  logic             timeout_err_q;
  logic             busy_q;
  logic             complete;
  logic             expire;

  // Transaction end conditions and the pending update (a new rise beats a clear).
  always_comb begin
    complete  = ((state_q == GRANT) && grant_ack && done) ||
                ((state_q == WAIT) && done);
    expire    = ((state_q == GRANT) || (state_q == WAIT)) && !complete &&
                (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    rise      = req_in & ~req_q;
    clr_mask  = (complete || expire) ? grant_onehot_q : '0;
    pending_d = (pending_q & ~clr_mask) | rise;
  end

  // Round-robin search: first pending bit after ptr, wrapping, ptr itself last.
  always_comb begin
    logic [ID_W-1:0] idx;
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = '0;
    for (int k = 1; k <= N_BUS; k++) begin
      idx = ID_W'((int'(ptr_q) + k) % N_BUS);
      if (!sel_found && pending_q[idx]) begin
        sel_found = 1'b1;
        sel_id    = idx;
      end
    end
  end

  // Request edge history and sticky pending vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q     <= '0;
      pending_q <= '0;
    end else begin
      req_q     <= req_in;
      pending_q <= pending_d;
    end
  end

  // Grant sequencing FSM with registered outputs and timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      ptr_q          <= ID_W'(N_BUS - 1);
      grant_id_q     <= '0;
      grant_onehot_q <= '0;
      grant_valid_q  <= 1'b0;
      timeout_err_q  <= 1'b0;
      busy_q         <= 1'b0;
      cnt_q          <= '0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en && (|pending_q)) begin
            state_q <= SELECT;
            busy_q  <= 1'b1;
          end
        end
        SELECT: begin
          if (sel_found) begin
            grant_id_q     <= sel_id;
            grant_onehot_q <= {{(N_BUS-1){1'b0}}, 1'b1} << sel_id;
            cnt_q          <= '0;
            grant_valid_q  <= 1'b1;
            state_q        <= GRANT;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        GRANT, WAIT: begin
          if (complete || expire) begin
            state_q        <= IDLE;
            grant_valid_q  <= 1'b0;
            grant_onehot_q <= '0;
            busy_q         <= 1'b0;
            ptr_q          <= grant_id_q;
            timeout_err_q  <= expire;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if ((state_q == GRANT) && grant_ack) begin
              state_q       <= WAIT;
              grant_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q       <= IDLE;
          grant_valid_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_id     = grant_id_q;
  assign grant_onehot = grant_onehot_q;
  assign timeout_err  = timeout_err_q;
  assign pending_out  = pending_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_node_irq_scheduler.sv
// Directed bench for node_irq_scheduler: a cycle-by-cycle vector table for the
// basic grant flow and round-robin ordering, plus hand sequences for wrap,
// timeout, set-beats-clear and enable/async-reset behaviour.
module tb_node_irq_scheduler;

  localparam int NB = 32;
  localparam int IW = 5;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] req_in;
  logic          en;
  logic          grant_valid;
  logic [IW-1:0] grant_id;
  logic [NB-1:0] grant_onehot;
  logic          grant_ack;
  logic          done;
  logic          timeout_err;
  logic [NB-1:0] pending_out;
  logic          busy;

  int total = 0;
  int bad   = 0;

  node_irq_scheduler #(
    .N_BUS(NB), .ID_W(IW), .TIMEOUT_CYC(TO), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .en(en),
    .grant_valid(grant_valid), .grant_id(grant_id), .grant_onehot(grant_onehot),
    .grant_ack(grant_ack), .done(done), .timeout_err(timeout_err),
    .pending_out(pending_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_before;
    logic [31:0] req;
    logic        en;
    logic        ack;
    logic        dn;
    logic        gv;
    logic [4:0]  gid;
    logic [31:0] oh;
    logic [31:0] pend;
    logic        busy;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit rb, logic [31:0] r, logic a, logic d, logic gv,
                              logic [4:0] gid, logic [31:0] oh, logic [31:0] pend,
                              logic b);
    vec_t v;
    v.rst_before = rb; v.req = r; v.en = 1'b1; v.ack = a; v.dn = d;
    v.gv = gv; v.gid = gid; v.oh = oh; v.pend = pend; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [31:0] r, input logic e, input logic a, input logic d);
    req_in = r; en = e; grant_ack = a; done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_in = '0; en = 1'b1; grant_ack = 1'b0; done = 1'b0;
    rst = 1'b1;
    #12;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Single request on bus 5
    tv.push_back(mk(1, 32'h0000_0020, 0, 0, 0, 5'd0,  32'h0,          32'h0000_0020, 0));
    tv.push_back(mk(0, 32'h0,         0, 0, 0, 5'd0,  32'h0,          32'h0000_0020, 1));
    tv.push_back(mk(0, 32'h0,         0, 0, 1, 5'd5,  32'h0000_0020,  32'h0000_0020, 1));
    tv.push_back(mk(0, 32'h0,         1, 1, 0, 5'd5,  32'h0,          32'h0,         0));
    // Fairness: 3, 7, 30 from reset pointer; levels held high never re-arm
    tv.push_back(mk(1, 32'h4000_0088, 0, 0, 0, 5'd0,  32'h0,          32'h4000_0088, 0));
    tv.push_back(mk(0, 32'h4000_0088, 0, 0, 0, 5'd0,  32'h0,          32'h4000_0088, 1));
    tv.push_back(mk(0, 32'h4000_0088, 0, 0, 1, 5'd3,  32'h0000_0008,  32'h4000_0088, 1));
    tv.push_back(mk(0, 32'h4000_0088, 1, 1, 0, 5'd3,  32'h0,          32'h4000_0080, 0));
    tv.push_back(mk(0, 32'h4000_0088, 0, 0, 0, 5'd3,  32'h0,          32'h4000_0080, 1));
    tv.push_back(mk(0, 32'h4000_0088, 0, 0, 1, 5'd7,  32'h0000_0080,  32'h4000_0080, 1));
    tv.push_back(mk(0, 32'h4000_0088, 0, 1, 1, 5'd7,  32'h0000_0080,  32'h4000_0080, 1));
    tv.push_back(mk(0, 32'h4000_0088, 1, 0, 0, 5'd7,  32'h0000_0080,  32'h4000_0080, 1));
    tv.push_back(mk(0, 32'h4000_0088, 0, 1, 0, 5'd7,  32'h0,          32'h4000_0000, 0));
    tv.push_back(mk(0, 32'h4000_0088, 0, 0, 0, 5'd7,  32'h0,          32'h4000_0000, 1));
    tv.push_back(mk(0, 32'h4000_0088, 0, 0, 1, 5'd30, 32'h4000_0000,  32'h4000_0000, 1));
    tv.push_back(mk(0, 32'h4000_0088, 1, 1, 0, 5'd30, 32'h0,          32'h0,         0));
    tv.push_back(mk(0, 32'h0,         0, 0, 0, 5'd30, 32'h0,          32'h0,         0));
    // Bits 3 and 4 after ptr=30: search 31,0,1,2,3 -> 3 first, then 4
    tv.push_back(mk(0, 32'h0000_0018, 0, 0, 0, 5'd30, 32'h0,          32'h0000_0018, 0));
    tv.push_back(mk(0, 32'h0,         0, 0, 0, 5'd30, 32'h0,          32'h0000_0018, 1));
    tv.push_back(mk(0, 32'h0,         0, 0, 1, 5'd3,  32'h0000_0008,  32'h0000_0018, 1));
    tv.push_back(mk(0, 32'h0,         1, 1, 0, 5'd3,  32'h0,          32'h0000_0010, 0));
    tv.push_back(mk(0, 32'h0,         0, 0, 0, 5'd3,  32'h0,          32'h0000_0010, 1));
    tv.push_back(mk(0, 32'h0,         0, 0, 1, 5'd4,  32'h0000_0010,  32'h0000_0010, 1));
    tv.push_back(mk(0, 32'h0,         1, 1, 0, 5'd4,  32'h0,          32'h0,         0));

    // Reset state
    do_reset();
    chk("rst grant_valid", 32'(grant_valid), 32'h0);
    chk("rst grant_id", 32'(grant_id), 32'h0);
    chk("rst grant_onehot", grant_onehot, 32'h0);
    chk("rst timeout_err", 32'(timeout_err), 32'h0);
    chk("rst pending_out", pending_out, 32'h0);
    chk("rst busy", 32'(busy), 32'h0);

    // Vector table
    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst_before) do_reset();
      step(tv[i].req, tv[i].en, tv[i].ack, tv[i].dn);
      chk($sformatf("vec%0d grant_valid", i), 32'(grant_valid), 32'(tv[i].gv));
      chk($sformatf("vec%0d grant_id", i), 32'(grant_id), 32'(tv[i].gid));
      chk($sformatf("vec%0d grant_onehot", i), grant_onehot, tv[i].oh);
      chk($sformatf("vec%0d pending_out", i), pending_out, tv[i].pend);
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tv[i].busy));
    end

    // Wrap: serve bus 31, then only bus 0 pending -> grant 0
    do_reset();
    step(32'h8000_0000, 1, 0, 0);
    step(32'h0, 1, 0, 0);
    step(32'h0, 1, 0, 0);
    chk("wrap first id", 32'(grant_id), 32'd31);
    step(32'h0, 1, 1, 1);
    step(32'h1, 1, 0, 0);
    step(32'h0, 1, 0, 0);
    step(32'h0, 1, 0, 0);
    chk("wrap grant_valid", 32'(grant_valid), 32'h1);
    chk("wrap id", 32'(grant_id), 32'd0);
    step(32'h0, 1, 1, 1);

    // Timeout on bus 9 (acked, never done), then bus 11 is granted
    do_reset();
    step(32'h0000_0A00, 1, 0, 0);
    step(32'h0, 1, 0, 0);
    step(32'h0, 1, 0, 0);
    chk("to grant id", 32'(grant_id), 32'd9);
    begin
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
        step(32'h0, 1, (n == 0), 0);
        n++;
        if (timeout_err) seen = 1'b1;
      end
      chk("to seen", 32'(seen), 32'h1);
      chk("to latency", 32'(n), 32'd16);
    end
    chk("to pending", pending_out, 32'h0000_0800);
    chk("to grant_valid", 32'(grant_valid), 32'h0);
    chk("to busy", 32'(busy), 32'h0);
    step(32'h0, 1, 0, 0);
    chk("to pulse width", 32'(timeout_err), 32'h0);
    chk("to select busy", 32'(busy), 32'h1);
    step(32'h0, 1, 0, 0);
    chk("to next id", 32'(grant_id), 32'd11);
    chk("to next valid", 32'(grant_valid), 32'h1);
    // Completion on the expiry cycle wins over timeout
    repeat (15) step(32'h0, 1, 0, 0);
    chk("edge still granted", 32'(grant_valid), 32'h1);
    step(32'h0, 1, 1, 1);
    chk("edge no timeout", 32'(timeout_err), 32'h0);
    chk("edge pending", pending_out, 32'h0);
    chk("edge busy", 32'(busy), 32'h0);

    // Re-raise of bus 12 in its completion cycle keeps it pending
    do_reset();
    step(32'h0000_1000, 1, 0, 0);
    step(32'h0, 1, 0, 0);
    step(32'h0, 1, 0, 0);
    step(32'h0, 1, 1, 0);
    chk("setclr in wait", 32'(grant_valid), 32'h0);
    step(32'h0000_1000, 1, 0, 1);
    chk("setclr pending", pending_out, 32'h0000_1000);
    chk("setclr idle", 32'(busy), 32'h0);
    step(32'h0000_1000, 1, 0, 0);
    step(32'h0000_1000, 1, 0, 0);
    chk("setclr regrant valid", 32'(grant_valid), 32'h1);
    chk("setclr regrant id", 32'(grant_id), 32'd12);
    step(32'h0, 1, 1, 1);

    // Enable gating and asynchronous reset during WAIT
    do_reset();
    step(32'h6, 0, 0, 0);
    step(32'h0, 0, 0, 0);
    step(32'h0, 0, 0, 0);
    step(32'h0, 0, 0, 0);
    chk("en0 grant_valid", 32'(grant_valid), 32'h0);
    chk("en0 busy", 32'(busy), 32'h0);
    chk("en0 pending", pending_out, 32'h6);
    step(32'h0, 1, 0, 0);
    step(32'h0, 1, 0, 0);
    chk("en1 id", 32'(grant_id), 32'd1);
    chk("en1 valid", 32'(grant_valid), 32'h1);
    step(32'h0, 0, 1, 0);
    chk("wait busy en0", 32'(busy), 32'h1);
    chk("wait onehot", grant_onehot, 32'h2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst grant_valid", 32'(grant_valid), 32'h0);
    chk("arst grant_id", 32'(grant_id), 32'h0);
    chk("arst grant_onehot", grant_onehot, 32'h0);
    chk("arst pending", pending_out, 32'h0);
    chk("arst busy", 32'(busy), 32'h0);
    chk("arst timeout_err", 32'(timeout_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
